// File: rtl/minimig_autoconfig_pkg.sv
// Shared types and constants for the Minimig Zorro autoconfig controller:
// FSM state encoding, board slot indices, autoconfig register offsets and
// the ZII size nibbles patched into the configuration ROM at start-up.
package minimig_autoconfig_pkg;

    typedef enum logic [2:0] {
        INIT,
        SEEK,
        IDLE,
        RD1,
        RD2,
        ACK,
        DONE
    } state_t;

    // Board slot indices; the slot number also selects the ROM page.
    localparam logic [1:0] BOARD_ZII = 2'd0;
    localparam logic [1:0] BOARD_Z3  = 2'd1;
    localparam logic [1:0] BOARD_Z3B = 2'd2;
    localparam logic [1:0] BOARD_ETH = 2'd3;

    // Autoconfig register byte offsets inside $E8xxxx.
    localparam logic [6:0] REG_Z3_BASE = 7'h44;
    localparam logic [6:0] REG_BASE_HI = 7'h48;
    localparam logic [6:0] REG_BASE_LO = 7'h4A;
    localparam logic [6:0] REG_SHUTUP  = 7'h4C;

    // Size nibble patched into the ZII board's er_Type field.
    localparam logic [3:0] SIZE_NIB_NONE = 4'b0000;
    localparam logic [3:0] SIZE_NIB_2MB  = 4'b0110;
    localparam logic [3:0] SIZE_NIB_4MB  = 4'b0111;
    localparam logic [3:0] SIZE_NIB_8MB  = 4'b0000;

    // ROM location of the ZII size nibble (board 0, offset 'h02).
    localparam logic [8:0] ROM_SIZE_IDX = 9'h001;

    function automatic logic [3:0] size_nibble(input logic [1:0] sz);
        logic [3:0] nib;
        case (sz)
            2'b01:   nib = SIZE_NIB_2MB;
            2'b10:   nib = SIZE_NIB_4MB;
            2'b11:   nib = SIZE_NIB_8MB;
            default: nib = SIZE_NIB_NONE;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/minimig_autoconfig_ctrl.sv
// Minimig autoconfig controller: walks the chain of enabled boards (ZII RAM,
// ZIII RAM, ZIII RAM2 and optionally ETH), serves CPU reads of $E8xxxx from
// an external nibble ROM and latches the base addresses software assigns.
// Optional feature macro: AUTOCONFIG_ETH_EN offers board 3 (ETH, ROM page 'hC0).
module minimig_autoconfig_ctrl
    import minimig_autoconfig_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    input  logic [3:0]  board_en,
    input  logic [1:0]  z2_size,
    output logic [8:0]  rom_a_read,
    input  logic [3:0]  rom_q,
    output logic [8:0]  rom_a_write,
    output logic [3:0]  rom_d,
    output logic        rom_we,
    output logic [7:0]  z2_base,
    output logic [15:0] z3_base,
    output logic [15:0] z3b_base,
    output logic [15:0] eth_base,
    output logic [3:0]  cfg_valid,
    output logic        config_done
);

`ifdef AUTOCONFIG_ETH_EN
    localparam logic [3:0] VALID_MASK = 4'b1111;
`else
    localparam logic [3:0] VALID_MASK = 4'b0111;
`endif

    state_t      state_reg;
    logic [1:0]  cur_reg;
    logic [3:0]  configured_reg;
    logic [3:0]  cfg_valid_reg;
    logic [3:0]  z2_lo_reg;
    logic [7:0]  z2_base_reg;
    logic [15:0] z3_base_reg;
    logic [15:0] z3b_base_reg;
    logic [15:0] rdata_reg;
    logic        ack_reg;
    logic        config_done_reg;
    logic [8:0]  rom_a_read_reg;

    logic [3:0]  board_allowed;
    logic [3:0]  pending;
    logic [1:0]  next_board;
    logic        next_found;
    logic [5:0]  reg_sel;
    logic        unused_addr_lsb;

    // Bit 0 of the byte offset never selects a register.
    assign reg_sel         = addr[6:1];
    assign unused_addr_lsb = addr[0];

    // Board 0 only exists when a ZII size is configured.
    assign board_allowed[BOARD_ZII] = board_en[BOARD_ZII] & (z2_size != 2'b00);

    genvar gi;
    generate
        for (gi = 1; gi < 3; gi++) begin : g_z3_allowed
            assign board_allowed[gi] = board_en[gi];
        end
    endgenerate

`ifdef AUTOCONFIG_ETH_EN
    logic [15:0] eth_base_reg;
    assign board_allowed[BOARD_ETH] = board_en[BOARD_ETH];
    assign eth_base                 = eth_base_reg;
`else
    logic unused_eth_en;
    assign unused_eth_en            = board_en[BOARD_ETH];
    assign board_allowed[BOARD_ETH] = 1'b0;
    assign eth_base                 = 16'h0000;
`endif

    assign pending = board_allowed & ~configured_reg;

    // Lowest-numbered board still waiting for configuration.
    always_comb begin
        next_board = 2'd0;
        next_found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                next_board = 2'(i);
                next_found = 1'b1;
            end
        end
    end

    // Main controller FSM with registered bus and configuration outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= INIT;
            cur_reg         <= BOARD_ZII;
            configured_reg  <= 4'b0000;
            cfg_valid_reg   <= 4'b0000;
            z2_lo_reg       <= 4'h0;
            z2_base_reg     <= 8'h00;
            z3_base_reg     <= 16'h0000;
            z3b_base_reg    <= 16'h0000;
`ifdef AUTOCONFIG_ETH_EN
            eth_base_reg    <= 16'h0000;
`endif
            rdata_reg       <= 16'hFFFF;
            ack_reg         <= 1'b0;
            config_done_reg <= 1'b0;
            rom_a_read_reg  <= 9'h000;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                INIT: state_reg <= SEEK;

                SEEK: begin
                    if (next_found) begin
                        cur_reg   <= next_board;
                        state_reg <= IDLE;
                    end else begin
                        config_done_reg <= 1'b1;
                        state_reg       <= DONE;
                    end
                end

                IDLE: begin
                    if (req && rw) begin
                        rom_a_read_reg <= {1'b0, cur_reg, reg_sel};
                        state_reg      <= RD1;
                    end else if (req) begin
                        ack_reg <= 1'b1;
                        if (reg_sel == REG_SHUTUP[6:1]) begin
                            configured_reg[cur_reg] <= 1'b1;
                            state_reg               <= SEEK;
                        end else if (cur_reg == BOARD_ZII) begin
                            if (reg_sel == REG_BASE_LO[6:1]) begin
                                z2_lo_reg <= wdata[15:12];
                            end else if (reg_sel == REG_BASE_HI[6:1]) begin
                                z2_base_reg                  <= {wdata[15:12], z2_lo_reg};
                                cfg_valid_reg[BOARD_ZII]     <= 1'b1;
                                configured_reg[BOARD_ZII]    <= 1'b1;
                                state_reg                    <= SEEK;
                            end
                        end else if (reg_sel == REG_Z3_BASE[6:1]) begin
                            case (cur_reg)
                                BOARD_Z3:  z3_base_reg  <= wdata;
                                BOARD_Z3B: z3b_base_reg <= wdata;
`ifdef AUTOCONFIG_ETH_EN
                                BOARD_ETH: eth_base_reg <= wdata;
`endif
                                default: ;
                            endcase
                            cfg_valid_reg[cur_reg]  <= 1'b1;
                            configured_reg[cur_reg] <= 1'b1;
                            state_reg               <= SEEK;
                        end
                    end
                end

                RD1: state_reg <= RD2;

                // The ROM has had the index for two cycles; its nibble is settled.
                RD2: begin
                    rdata_reg <= {rom_q, 12'hFFF};
                    ack_reg   <= 1'b1;
                    state_reg <= ACK;
                end

                ACK: state_reg <= IDLE;

                DONE: begin
                    if (req) begin
                        rdata_reg <= 16'hFFFF;
                        ack_reg   <= 1'b1;
                    end
                end

                default: state_reg <= INIT;
            endcase
        end
    end

    // The size patch must land in the single INIT cycle, so the write strobe
    // follows the state directly and is held off while reset is asserted.
    assign rom_we      = (state_reg == INIT) & ~reset;
    assign rom_a_write = ROM_SIZE_IDX;
    assign rom_d       = size_nibble(z2_size);

    assign rdata       = rdata_reg;
    assign ack         = ack_reg;
    assign rom_a_read  = rom_a_read_reg;
    assign z2_base     = z2_base_reg;
    assign z3_base     = z3_base_reg;
    assign z3b_base    = z3b_base_reg;
    assign cfg_valid   = cfg_valid_reg & VALID_MASK;
    assign config_done = config_done_reg;

endmodule
